// File: rtl/sram_access_initiator_pkg.sv
// Shared constants and the FSM state encoding for the SRAM access initiator.
// No ports.
package sram_access_initiator_pkg;

  localparam int unsigned WORD_LEN    = 32;
  localparam int unsigned ADDRESS_LEN = 32;
  localparam int unsigned SRAM_DATA_W = 16;
  // Width of the per-phase wait counter; WAIT_CYCLES is limited to 0..15.
  localparam int unsigned CNT_W       = 4;

  localparam logic [ADDRESS_LEN-1:0] BASE_ADDR_DEFAULT = 32'd1024;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLo   = 2'd1,
    StHi   = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/sram_access_initiator_if.sv
// Bundle of the pipeline-side request/response signals and the SRAM pin signals.
// master: the initiator (drives ready/rdata and the SRAM strobes).
// slave : the environment (pipeline requests and SRAM read data).
interface sram_access_initiator_if
  import sram_access_initiator_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_W = 18
);
  logic                   mem_r_en;
  logic                   mem_w_en;
  logic [ADDRESS_LEN-1:0] alu_res;
  logic [WORD_LEN-1:0]    val_rm;
  logic [WORD_LEN-1:0]    rdata;
  logic                   ready;
  logic                   addr_err;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [SRAM_DATA_W-1:0] sram_dq_out;
  logic                   sram_dq_oe;
  logic [SRAM_DATA_W-1:0] sram_dq_in;
  logic                   sram_ce_n;
  logic                   sram_we_n;

  modport master (
    input  mem_r_en, mem_w_en, alu_res, val_rm, sram_dq_in,
    output rdata, ready, addr_err, sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_we_n
  );

  modport slave (
    output mem_r_en, mem_w_en, alu_res, val_rm, sram_dq_in,
    input  rdata, ready, addr_err, sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_we_n
  );

endinterface

// File: rtl/sram_access_initiator_phase_timer.sv
// sram_phase_timer: wait counter for one half-word phase, reused for both halves.
// Ports: clk, rst_n (async active-low), start_i (clear for a new transaction),
//        en_i (a phase is active), cnt_next_o (next counter value, for registered
//        strobes), done_o (last cycle of the current phase).
module sram_phase_timer
  import sram_access_initiator_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_next_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WAIT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done_o = en_i && (cnt_q == LastCnt);

  // Wraps to 0 on done so the HI phase starts fresh straight after LO.
  always_comb begin
    cnt_d = '0;
    if (!start_i && en_i && !done_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign cnt_next_o = cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_access_initiator.sv
// sram_access_initiator: turns a 32-bit word read/write from the memory stage into
// two half-word accesses on a 16-bit asynchronous SRAM, freezing the pipeline with
// ready=0 until the access completes.
// Ports: clk, rst_n (async active-low), bus (sram_access_initiator_if.master:
//        pipeline request/response plus SRAM pins).
// Build option: define ADDR_CHECK_EN to flag out-of-range addresses on addr_err
// and skip the SRAM access; otherwise addr_err is tied low and addresses truncate.
module sram_access_initiator
  import sram_access_initiator_pkg::*;
#(
  parameter logic [ADDRESS_LEN-1:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int unsigned            SRAM_ADDR_W = 18,
  parameter int unsigned            WAIT_CYCLES = 2,
  parameter int unsigned            MEM_WORDS   = 65536
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sram_access_initiator_if.master  bus
);

  localparam int unsigned      WidxW   = SRAM_ADDR_W - 1;
  localparam logic [CNT_W-1:0] WaitCnt = CNT_W'(WAIT_CYCLES);

  state_e                 state_q, state_d;
  logic [WidxW-1:0]       widx_q, widx_d;
  logic [WORD_LEN-1:0]    wdata_q, wdata_d;
  logic                   write_q, write_d;
  logic [SRAM_DATA_W-1:0] rd_lo_q, rd_lo_d;
  logic [WORD_LEN-1:0]    rdata_q, rdata_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [SRAM_DATA_W-1:0] dq_out_q, dq_out_d;
  logic                   oe_q, oe_d;
  logic                   ce_n_q, ce_n_d;
  logic                   we_n_q, we_n_d;
  logic                   err_q, err_d;

  logic                   req;
  logic [ADDRESS_LEN-1:0] off;
  logic                   oor;
  logic                   in_phase;
  logic                   timer_start;
  logic                   phase_done;
  logic [CNT_W-1:0]       cnt_d;
  logic                   active_d;
  logic                   unused_off_bits;

  assign req = bus.mem_r_en | bus.mem_w_en;
  // Below-base addresses wrap to huge offsets, which the range check then catches.
  assign off = bus.alu_res - BASE_ADDR;
  assign unused_off_bits = ^{off[1:0], off[ADDRESS_LEN-1:WidxW+2]};

`ifdef ADDR_CHECK_EN
  assign oor = ({32'd0, off} >= (64'(MEM_WORDS) << 2));
`else
  assign oor = 1'b0;
`endif

  assign in_phase = (state_q == StLo) || (state_q == StHi);

  sram_phase_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (timer_start),
    .en_i      (in_phase),
    .cnt_next_o(cnt_d),
    .done_o    (phase_done)
  );

  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    rd_lo_d     = rd_lo_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    timer_start = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          widx_d  = off[WidxW+1:2];
          wdata_d = bus.val_rm;
          write_d = bus.mem_w_en;
          if (oor) begin
            state_d = StDone;
            err_d   = 1'b1;
            if (!bus.mem_w_en) rdata_d = '0;
          end else begin
            state_d     = StLo;
            timer_start = 1'b1;
          end
        end
      end
      StLo: begin
        if (phase_done) begin
          state_d = StHi;
          if (!write_q) rd_lo_d = bus.sram_dq_in;
        end
      end
      StHi: begin
        if (phase_done) begin
          state_d = StDone;
          // rdata only changes on the edge into DONE, so it holds the last read word.
          if (!write_q) rdata_d = {bus.sram_dq_in, rd_lo_q};
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Pin strobes are registered from next-state values so they line up with the state.
    active_d = (state_d == StLo) || (state_d == StHi);
    ce_n_d   = !active_d;
    oe_d     = active_d && write_d && (cnt_d < WaitCnt);
    we_n_d   = !oe_d;
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    if (active_d) begin
      addr_d   = {widx_d, state_d == StHi};
      dq_out_d = (state_d == StHi) ? wdata_d[31:16] : wdata_d[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      widx_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      rd_lo_q  <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      dq_out_q <= '0;
      oe_q     <= 1'b0;
      ce_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      rd_lo_q  <= rd_lo_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      oe_q     <= oe_d;
      ce_n_q   <= ce_n_d;
      we_n_q   <= we_n_d;
      err_q    <= err_d;
    end
  end

  assign bus.ready       = ((state_q == StIdle) && !req) || (state_q == StDone);
  assign bus.rdata       = rdata_q;
  assign bus.addr_err    = err_q;
  assign bus.sram_addr   = addr_q;
  assign bus.sram_dq_out = dq_out_q;
  assign bus.sram_dq_oe  = oe_q;
  assign bus.sram_ce_n   = ce_n_q;
  assign bus.sram_we_n   = we_n_q;

endmodule
